instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Parametrised successor to the current PC-plus-instruction-memory front end.
- Holds the program counter and an internal synchronous instruction ROM, and presents one instruction per cycle to decode.
- Adds what the current block lacks: word/byte addressing modes, a configurable reset vector and memory depth, a pipeline stall, redirect priority rules, and a valid flag, fault flags and a fetch counter on the output.
- Sits between branch/jump resolution (redirect source) and the IF/ID boundary.

Parameters:
- XLEN, 32, width of PC, redirect target and instruction.
- IM_DEPTH, 256, number of XLEN-bit words in the ROM; power of two, at least 2.
- PC_STEP, 1, PC increment. 1 = word-addressed, 4 = byte-addressed; no other values are legal.
- RESET_PC, 0, PC value loaded on reset.
- INIT_FILE, "im_init.hex", $readmemh image for the ROM.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the fetch stage; outputs and PC are frozen.
- redirect_valid  in  1  a taken branch or jump this cycle.
- redirect_pc  in  XLEN  branch or jump target.
- ins  out  XLEN  fetched instruction (registered).
- ins_pc  out  XLEN  address of ins (registered).
- ins_valid  out  1  ins/ins_pc carry a real fetch.
- fetch_fault  out  2  bit0 = misaligned, bit1 = out of range (registered, qualified by ins_valid).
- fetch_count  out  32  number of valid fetches since reset.

Behaviour:
- Internal state: pc_q (XLEN), ROM array, output registers.
- Fetch address, combinational: fa = redirect_valid ? redirect_pc : pc_q.
- Word index: idx = fa / PC_STEP, low log2(PC_STEP) bits dropped.
- Misaligned: PC_STEP=4 and fa[1:0] != 0. Always 0 when PC_STEP=1.
- Out of range: idx >= IM_DEPTH. Upper bits are not silently truncated.
- Reset (reset=1 at edge), taking priority over everything:
  - pc_q <= RESET_PC.
  - ins <= 0, ins_pc <= 0, ins_valid <= 0, fetch_fault <= 0, fetch_count <= 0.
- Normal edge (reset=0, stall=0):
  - ins <= ROM[idx], or 0 if any fault.
  - ins_pc <= fa, ins_valid <= 1, fetch_fault <= {oor, mis}.
  - pc_q <= fa + PC_STEP, wrapping modulo 2^XLEN.
  - fetch_count <= fetch_count + 1.
  - Read latency is one cycle. The first edge after reset deasserts presents ins_pc = RESET_PC with ins_valid = 1.
- Redirect with stall=0: takes effect with zero bubble. The next output is ins_pc = redirect_pc, and pc_q becomes redirect_pc + PC_STEP.
- Stall (reset=0, stall=1, redirect_valid=0): pc_q, ins, ins_pc, ins_valid, fetch_fault and fetch_count all hold their values. No ROM read is consumed.
- Stall and redirect in the same cycle: redirect wins the PC.
  - pc_q <= redirect_pc (no increment), ins_valid <= 0, fetch_fault <= 0; ins and ins_pc hold; no count.
  - When stall releases, the first fetch is redirect_pc.
- Faulted fetches still count and still advance the PC. The fault is reported, never trapped, here.
- Wrap-around: pc_q at 2^XLEN - PC_STEP advances to 0.
- fetch_count wraps modulo 2^32.
- Reset asserted mid-stall or mid-redirect: reset wins at that edge, with no partial update.
- ROM has no write port.
- Elaboration must fail if PC_STEP is not 1 or 4, or if IM_DEPTH is not a power of two.

Test Plan:
- Reset, then free-run, PC_STEP=1, ROM[i]=0x1000+i: ins_valid=1 from the first edge after release; ins_pc = 0,1,2,3 and ins = 0x1000, 0x1001, 0x1002, 0x1003; fetch_count = 4.
- PC_STEP=4, RESET_PC=0x10: ins_pc = 0x10, 0x14, 0x18 with ins = ROM[4], ROM[5], ROM[6].
  - Then redirect_pc=0x22 with no stall: next ins_pc = 0x22, fetch_fault = 2'b01, ins = 0.
- Stall held 3 cycles while ins_pc=5: ins, ins_pc, ins_valid and fetch_count are unchanged for 3 cycles; ins_pc=6 on the first unstalled edge.
- Stall and redirect_valid together (redirect_pc=0x40, PC_STEP=1): ins_valid=0 that edge, count unchanged.
  - Release stall: ins_pc = 0x40, then 0x41.
- IM_DEPTH=256, PC_STEP=1, redirect to 0xFF: ins_pc 0xFF with fault 00, then 0x100 with fault 2'b10 and ins = 0.
  - Redirect to 0xFFFFFFFF: the next fetch wraps to pc 0 with fault 00.
- Assert reset for one cycle mid-run while stalled: all outputs are zero the next cycle; the following edge presents ins_pc = RESET_PC and fetch_count = 1.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the program counter and an internal instruction ROM, and delivers one
// registered instruction per cycle to decode, with stall, redirect, fault flags and a fetch count.
module instr_fetch_unit #(
    parameter int               XLEN      = 32,
    parameter int               IM_DEPTH  = 256,
    parameter int               PC_STEP   = 1,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter string            INIT_FILE = "im_init.hex"
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] ins,
    output logic [XLEN-1:0] ins_pc,
    output logic            ins_valid,
    output logic [1:0]      fetch_fault,
    output logic [31:0]     fetch_count
);

    localparam int IDX_W = $clog2(IM_DEPTH);
    localparam int SHIFT = (PC_STEP == 4) ? 2 : 0;

    if (!(PC_STEP == 1 || PC_STEP == 4)) begin : g_bad_step
        $error("instr_fetch_unit: PC_STEP must be 1 or 4");
    end
    if (IM_DEPTH < 2 || (IM_DEPTH & (IM_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_fetch_unit: IM_DEPTH must be a power of two and at least 2");
    end

    logic [XLEN-1:0] rom [IM_DEPTH];

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ins_q, ins_d;
    logic [XLEN-1:0] ins_pc_q, ins_pc_d;
    logic            ins_valid_q, ins_valid_d;
    logic [1:0]      fault_q, fault_d;
    logic [31:0]     count_q, count_d;

    logic [XLEN-1:0] fa;
    logic [XLEN-1:0] word;
    logic            mis;
    logic            oor;

    assign fa   = redirect_valid ? redirect_pc : pc_q;
    assign word = fa >> SHIFT;
    // Range check looks at every bit above the ROM index so high addresses never alias low words.
    assign oor  = |(word >> IDX_W);
    assign mis  = (PC_STEP == 4) && (fa[1:0] != 2'b00);

    always_comb begin
        pc_d        = pc_q;
        ins_d       = ins_q;
        ins_pc_d    = ins_pc_q;
        ins_valid_d = ins_valid_q;
        fault_d     = fault_q;
        count_d     = count_q;
        if (!stall) begin
            pc_d        = fa + XLEN'(PC_STEP);
            ins_d       = (oor || mis) ? '0 : rom[word[IDX_W-1:0]];
            ins_pc_d    = fa;
            ins_valid_d = 1'b1;
            fault_d     = {oor, mis};
            count_d     = count_q + 32'd1;
        end else if (redirect_valid) begin
            // Stalled redirect: capture the target un-incremented so it is the first fetch on release.
            pc_d        = redirect_pc;
            ins_valid_d = 1'b0;
            fault_d     = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            ins_q       <= '0;
            ins_pc_q    <= '0;
            ins_valid_q <= 1'b0;
            fault_q     <= 2'b00;
            count_q     <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            ins_pc_q    <= ins_pc_d;
            ins_valid_q <= ins_valid_d;
            fault_q     <= fault_d;
            count_q     <= count_d;
        end
    end

    assign ins         = ins_q;
    assign ins_pc      = ins_pc_q;
    assign ins_valid   = ins_valid_q;
    assign fetch_fault = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a word-addressed and a byte-addressed instance driven from one
// vector table, with expected outputs queued at drive time and compared after each edge.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        r1 = 1'b1, s1 = 1'b0, v1 = 1'b0;
    logic [31:0] p1 = '0;
    logic [31:0] i1, ip1, c1;
    logic        iv1;
    logic [1:0]  f1;

    logic        r4 = 1'b1, s4 = 1'b0, v4 = 1'b0;
    logic [31:0] p4 = '0;
    logic [31:0] i4, ip4, c4;
    logic        iv4;
    logic [1:0]  f4;

    instr_fetch_unit #(
        .XLEN(32), .IM_DEPTH(256), .PC_STEP(1), .RESET_PC(32'h0), .INIT_FILE("")
    ) u_w (
        .clk(clk), .reset(r1), .stall(s1), .redirect_valid(v1), .redirect_pc(p1),
        .ins(i1), .ins_pc(ip1), .ins_valid(iv1), .fetch_fault(f1), .fetch_count(c1)
    );

    instr_fetch_unit #(
        .XLEN(32), .IM_DEPTH(256), .PC_STEP(4), .RESET_PC(32'h10), .INIT_FILE("")
    ) u_b (
        .clk(clk), .reset(r4), .stall(s4), .redirect_valid(v4), .redirect_pc(p4),
        .ins(i4), .ins_pc(ip4), .ins_valid(iv4), .fetch_fault(f4), .fetch_count(c4)
    );

    typedef struct {
        logic        sel;
        logic        rst;
        logic        stl;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
        logic        e_vld;
        logic [1:0]  e_flt;
        logic [31:0] e_cnt;
    } vec_t;

    typedef struct {
        int          id;
        logic        sel;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        vld;
        logic [1:0]  flt;
        logic [31:0] cnt;
    } exp_t;

    vec_t tv[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic sel, input logic rst, input logic stl, input logic rv,
                                input logic [31:0] rpc, input logic [31:0] e_ins,
                                input logic [31:0] e_pc, input logic e_vld,
                                input logic [1:0] e_flt, input logic [31:0] e_cnt);
        vec_t v;
        v.sel = sel; v.rst = rst; v.stl = stl; v.rv = rv; v.rpc = rpc;
        v.e_ins = e_ins; v.e_pc = e_pc; v.e_vld = e_vld; v.e_flt = e_flt; v.e_cnt = e_cnt;
        tv.push_back(v);
    endfunction

    task automatic check_out();
        exp_t        e;
        logic [31:0] a_ins, a_pc, a_cnt;
        logic        a_vld;
        logic [1:0]  a_flt;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        if (e.sel == 1'b0) begin
            a_ins = i1; a_pc = ip1; a_vld = iv1; a_flt = f1; a_cnt = c1;
        end else begin
            a_ins = i4; a_pc = ip4; a_vld = iv4; a_flt = f4; a_cnt = c4;
        end
        if ({a_ins, a_pc, a_vld, a_flt, a_cnt} !== {e.ins, e.pc, e.vld, e.flt, e.cnt}) begin
            errors++;
            $display("FAIL vec%0d step%0d: got ins=%h pc=%h vld=%b flt=%b cnt=%0d, want ins=%h pc=%h vld=%b flt=%b cnt=%0d",
                     e.id, PC_STEP_OF(e.sel), a_ins, a_pc, a_vld, a_flt, a_cnt,
                     e.ins, e.pc, e.vld, e.flt, e.cnt);
        end
    endtask

    function automatic int PC_STEP_OF(input logic sel);
        return sel ? 4 : 1;
    endfunction

    task automatic apply(input vec_t v, input int id);
        exp_t e;
        @(negedge clk);
        if (v.sel == 1'b0) begin
            r1 = v.rst; s1 = v.stl; v1 = v.rv; p1 = v.rpc;
            r4 = 1'b1;  s4 = 1'b0;  v4 = 1'b0; p4 = '0;
        end else begin
            r4 = v.rst; s4 = v.stl; v4 = v.rv; p4 = v.rpc;
            r1 = 1'b1;  s1 = 1'b0;  v1 = 1'b0; p1 = '0;
        end
        e.id = id; e.sel = v.sel; e.ins = v.e_ins; e.pc = v.e_pc;
        e.vld = v.e_vld; e.flt = v.e_flt; e.cnt = v.e_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            u_w.rom[i] = 32'h1000 + i;
            u_b.rom[i] = 32'h1000 + i;
        end

        // Word-addressed instance: reset, free-run, 3-cycle stall, stalled redirect,
        // range edge, 32-bit wrap, redirects, then reset during stall and during redirect.
        //   sel rst stl rv  rpc            ins           pc            vld flt    cnt
        add(0, 1, 0, 0, 32'h0,        32'h0,        32'h0,        0, 2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h1000,     32'h0,        1, 2'b00, 1);
        add(0, 0, 0, 0, 32'h0,        32'h1001,     32'h1,        1, 2'b00, 2);
        add(0, 0, 0, 0, 32'h0,        32'h1002,     32'h2,        1, 2'b00, 3);
        add(0, 0, 0, 0, 32'h0,        32'h1003,     32'h3,        1, 2'b00, 4);
        add(0, 0, 0, 0, 32'h0,        32'h1004,     32'h4,        1, 2'b00, 5);
        add(0, 0, 0, 0, 32'h0,        32'h1005,     32'h5,        1, 2'b00, 6);
        add(0, 0, 1, 0, 32'h0,        32'h1005,     32'h5,        1, 2'b00, 6);
        add(0, 0, 1, 0, 32'h0,        32'h1005,     32'h5,        1, 2'b00, 6);
        add(0, 0, 1, 0, 32'h0,        32'h1005,     32'h5,        1, 2'b00, 6);
        add(0, 0, 0, 0, 32'h0,        32'h1006,     32'h6,        1, 2'b00, 7);
        add(0, 0, 1, 1, 32'h40,       32'h1006,     32'h6,        0, 2'b00, 7);
        add(0, 0, 1, 0, 32'h0,        32'h1006,     32'h6,        0, 2'b00, 7);
        add(0, 0, 0, 0, 32'h0,        32'h1040,     32'h40,       1, 2'b00, 8);
        add(0, 0, 0, 0, 32'h0,        32'h1041,     32'h41,       1, 2'b00, 9);
        add(0, 0, 0, 1, 32'hFF,       32'h10FF,     32'hFF,       1, 2'b00, 10);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h100,      1, 2'b10, 11);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h101,      1, 2'b10, 12);
        add(0, 0, 0, 1, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 1, 2'b10, 13);
        add(0, 0, 0, 0, 32'h0,        32'h1000,     32'h0,        1, 2'b00, 14);
        add(0, 0, 0, 1, 32'h20,       32'h1020,     32'h20,       1, 2'b00, 15);
        add(0, 0, 0, 0, 32'h0,        32'h1021,     32'h21,       1, 2'b00, 16);
        add(0, 0, 1, 0, 32'h0,        32'h1021,     32'h21,       1, 2'b00, 16);
        add(0, 1, 1, 0, 32'h0,        32'h0,        32'h0,        0, 2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h1000,     32'h0,        1, 2'b00, 1);
        add(0, 1, 0, 1, 32'h55,       32'h0,        32'h0,        0, 2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h1000,     32'h0,        1, 2'b00, 1);

        for (int k = 0; k < tv.size(); k++) apply(tv[k], k);

        // Byte-addressed instance, reset vector 0x10: misaligned redirect, top ROM word,
        // first out-of-range byte address, wrap from 0xFFFFFFFC, and both faults together.
        tv.delete();
        add(1, 1, 0, 0, 32'h0,        32'h0,        32'h0,        0, 2'b00, 0);
        add(1, 0, 0, 0, 32'h0,        32'h1004,     32'h10,       1, 2'b00, 1);
        add(1, 0, 0, 0, 32'h0,        32'h1005,     32'h14,       1, 2'b00, 2);
        add(1, 0, 0, 0, 32'h0,        32'h1006,     32'h18,       1, 2'b00, 3);
        add(1, 0, 0, 1, 32'h22,       32'h0,        32'h22,       1, 2'b01, 4);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h26,       1, 2'b01, 5);
        add(1, 0, 0, 1, 32'h3FC,      32'h10FF,     32'h3FC,      1, 2'b00, 6);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h400,      1, 2'b10, 7);
        add(1, 0, 0, 1, 32'hFFFFFFFC, 32'h0,        32'hFFFFFFFC, 1, 2'b10, 8);
        add(1, 0, 0, 0, 32'h0,        32'h1000,     32'h0,        1, 2'b00, 9);
        add(1, 0, 0, 1, 32'h403,      32'h0,        32'h403,      1, 2'b11, 10);
        add(1, 0, 1, 1, 32'h8,        32'h0,        32'h403,      0, 2'b00, 10);
        add(1, 0, 0, 0, 32'h0,        32'h1002,     32'h8,        1, 2'b00, 11);
        add(1, 0, 0, 0, 32'h0,        32'h1003,     32'hC,        1, 2'b00, 12);

        for (int k = 0; k < tv.size(); k++) apply(tv[k], 100 + k);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
